seg_scan: RTL and testbench

Parametrised multi-digit seven-segment scan controller for the board-level wrapper. It latches a packed hex word, cycles through `NDIG` common-anode digits at a divided refresh rate, and drives active-low anode and segment lines. Beyond the fixed 8-digit scanner it adds tear-free frame-synchronous updates, per-digit enable, decimal points, leading-zero blanking and 8-level PWM brightness. It sits between the core's debug/data taps and the board pins `an`/`seg`.

---
 rtl/seg_scan_if.sv | 26 ++
 rtl/seg_scan.sv | 151 +++++++++++++++
 tb/tb_seg_scan.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan display bus: data/control in, pin drives out.
// master drives the value to show; slave is the scanner.
interface seg_scan_if #(
  parameter int NDIG = 8
);
  logic [4*NDIG-1:0] data;
  logic              load;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   digen;
  logic              lzb;
  logic [2:0]        bright;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic              dp_n;
  logic              frame;

  modport master (
    output data, load, dp, digen, lzb, bright,
    input  an, seg, dp_n, frame
  );

  modport slave (
    input  data, load, dp, digen, lzb, bright,
    output an, seg, dp_n, frame
  );
endinterface

// File: rtl/seg_scan.sv
// Multi-digit seven-segment scanner with frame-synchronous
// updates, per-digit enable, LZ blanking and PWM brightness.
module seg_scan #(
  parameter  int NDIG     = 8,
  parameter  int DIV_LOG2 = 15,
  localparam int IDXW     = $clog2(NDIG)
) (
  input  logic      CLK100MHZ,
  input  logic      reset,
  seg_scan_if.slave bus
);

  logic [DIV_LOG2-1:0] r_pre;
  logic [IDXW-1:0]     r_idx;
  logic [4*NDIG-1:0]   r_sh_data;
  logic [NDIG-1:0]     r_sh_dp;
  logic                r_pend;
  logic [4*NDIG-1:0]   r_disp;
  logic [NDIG-1:0]     r_disp_dp;
  logic [NDIG-1:0]     r_an;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic                r_frame;

  logic                w_tick;
  logic                w_last;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic                w_hi_zero;
  logic                w_lzblank;
  logic                w_pwm;
  logic                w_vis;
  logic [NDIG-1:0]     w_an_sel;
  logic [6:0]          w_glyph;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    glyph = 7'h7F;
    unique case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  endfunction

  assign w_tick  = &r_pre;
  assign w_last  = (r_idx == IDXW'(NDIG - 1));
  assign w_wrap  = w_tick && w_last;
  assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
  assign w_glyph = glyph(w_nib);
  assign w_pwm   = (r_pre[DIV_LOG2-1 -: 3] <= bus.bright);
  assign w_an_sel =
    ~({{(NDIG-1){1'b0}}, 1'b1} << r_idx);

  // Digits at and above the current one all zero -> blankable
  always_comb begin
    w_hi_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(r_idx) && r_disp[4*i +: 4] != 4'h0)
        w_hi_zero = 1'b0;
    end
  end

  assign w_lzblank = bus.lzb && (r_idx != '0) && w_hi_zero;
  assign w_vis = bus.digen[r_idx] && !w_lzblank && w_pwm;

  // Refresh divider and digit index
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (w_tick)
        r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Shadow capture and pending flag
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_sh_data <= '0;
      r_sh_dp   <= '0;
      r_pend    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_sh_data <= bus.data;
        r_sh_dp   <= bus.dp;
      end
      if (bus.load && !w_wrap)
        r_pend <= 1'b1;
      else if (w_wrap)
        r_pend <= 1'b0;
    end
  end

  // Display register swaps only at frame wrap (tear-free)
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_disp    <= '0;
      r_disp_dp <= '0;
    end else if (w_wrap) begin
      if (bus.load) begin
        r_disp    <= bus.data;
        r_disp_dp <= bus.dp;
      end else if (r_pend) begin
        r_disp    <= r_sh_data;
        r_disp_dp <= r_sh_dp;
      end
    end
  end

  // Registered pin drive and frame pulse
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      if (w_vis) begin
        r_an   <= w_an_sel;
        r_seg  <= w_glyph;
        r_dp_n <= ~r_disp_dp[r_idx];
      end else begin
        r_an   <= '1;
        r_seg  <= 7'h7F;
        r_dp_n <= 1'b1;
      end
    end
  end

  assign bus.an    = r_an;
  assign bus.seg   = r_seg;
  assign bus.dp_n  = r_dp_n;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan, NDIG=8, DIV_LOG2=3.
// Outputs sampled 1 time unit after each rising edge.
module tb_seg_scan;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lit;

  seg_scan_if #(.NDIG(8)) bus ();

  seg_scan #(.NDIG(8), .DIV_LOG2(3)) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.data   = '0;
    bus.load   = 1'b0;
    bus.dp     = '0;
    bus.digen  = 8'hFF;
    bus.lzb    = 1'b0;
    bus.bright = 3'd7;

    // reset held 3 cycles
    repeat (3) step();
    chk("rst_an", bus.an, 8'hFF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp_n, 1'b1);
    chk("rst_frame", bus.frame, 1'b0);
    reset = 1'b0;
    cyc = 0;

    // plain scan of zeros
    goto(1);
    chk("scan0_an", bus.an, 8'hFE);
    chk("scan0_seg", bus.seg, 7'b1000000);
    goto(9);
    chk("scan1_an", bus.an, 8'hFD);
    goto(57);
    chk("scan7_an", bus.an, 8'h7F);
    chk("scan7_seg", bus.seg, 7'b1000000);
    goto(63);
    chk("frame_pre", bus.frame, 1'b0);
    goto(64);
    chk("frame_on", bus.frame, 1'b1);
    goto(65);
    chk("frame_off", bus.frame, 1'b0);
    chk("f2_an", bus.an, 8'hFE);

    // mid-frame load, shown only after wrap
    goto(79);
    bus.data = 32'h0123_ABCF;
    bus.dp   = 8'h01;
    bus.load = 1'b1;
    goto(80);
    bus.load = 1'b0;
    goto(81);
    chk("old_an", bus.an, 8'hFB);
    chk("old_seg", bus.seg, 7'b1000000);
    goto(128);
    chk("old_d7", bus.seg, 7'b1000000);
    chk("frame2", bus.frame, 1'b1);
    goto(129);
    chk("new_d0_an", bus.an, 8'hFE);
    chk("new_d0_seg", bus.seg, 7'b0001110);
    chk("new_d0_dp", bus.dp_n, 1'b0);
    goto(137);
    chk("new_d1_seg", bus.seg, 7'b1000110);
    chk("new_d1_dp", bus.dp_n, 1'b1);

    // queue 0000_0A05 for leading-zero test
    goto(139);
    bus.data = 32'h0000_0A05;
    bus.dp   = 8'h00;
    bus.load = 1'b1;
    goto(140);
    bus.load = 1'b0;
    goto(185);
    chk("new_d7_an", bus.an, 8'h7F);
    chk("new_d7_seg", bus.seg, 7'b1000000);
    goto(192);
    bus.lzb = 1'b1;
    goto(193);
    chk("lz_d0", bus.seg, 7'b0010010);
    goto(199);
    bus.data = 32'h0;
    bus.load = 1'b1;
    goto(200);
    bus.load = 1'b0;
    goto(201);
    chk("lz_d1_an", bus.an, 8'hFD);
    chk("lz_d1_seg", bus.seg, 7'b1000000);
    goto(209);
    chk("lz_d2", bus.seg, 7'b0001000);
    goto(217);
    chk("lz_d3_an", bus.an, 8'hFF);
    chk("lz_d3_seg", bus.seg, 7'h7F);
    goto(249);
    chk("lz_d7_an", bus.an, 8'hFF);
    goto(257);
    chk("lz0_d0_an", bus.an, 8'hFE);
    chk("lz0_d0_seg", bus.seg, 7'b1000000);
    goto(265);
    chk("lz0_d1_an", bus.an, 8'hFF);

    // brightness and digit enable
    goto(320);
    bus.lzb = 1'b0;
    bus.bright = 3'd0;
    lit = 0;
    repeat (8) begin
      step();
      if (bus.an != 8'hFF) lit++;
    end
    chk("bright0", lit, 1);
    bus.bright = 3'd3;
    lit = 0;
    repeat (8) begin
      step();
      if (bus.an != 8'hFF) lit++;
    end
    chk("bright3", lit, 4);
    bus.bright = 3'd7;
    bus.digen = 8'hF0;
    goto(337);
    chk("digen_d2", bus.an, 8'hFF);
    goto(345);
    chk("digen_d3", bus.an, 8'hFF);
    goto(353);
    chk("digen_d4", bus.an, 8'hEF);
    bus.digen = 8'hFF;

    // two loads in a frame, last wins
    goto(389);
    bus.data = 32'h1111_1111;
    bus.load = 1'b1;
    goto(390);
    bus.load = 1'b0;
    goto(399);
    bus.data = 32'h2222_2222;
    bus.load = 1'b1;
    goto(400);
    bus.load = 1'b0;
    goto(449);
    chk("two_d0", bus.seg, 7'b0100100);
    goto(473);
    chk("two_d3_an", bus.an, 8'hF7);
    chk("two_d3_seg", bus.seg, 7'b0100100);

    // load coincident with wrap tick
    goto(511);
    bus.data = 32'h3333_3333;
    bus.load = 1'b1;
    goto(512);
    bus.load = 1'b0;
    chk("coin_old", bus.seg, 7'b0100100);
    goto(513);
    chk("coin_new", bus.seg, 7'b0110000);

    // reset with a pending load
    goto(519);
    bus.data = 32'h5555_5555;
    bus.load = 1'b1;
    goto(520);
    bus.load = 1'b0;
    goto(529);
    reset = 1'b1;
    goto(530);
    chk("mrst_an", bus.an, 8'hFF);
    chk("mrst_seg", bus.seg, 7'h7F);
    chk("mrst_dp", bus.dp_n, 1'b1);
    goto(531);
    reset = 1'b0;
    cyc = 0;
    goto(1);
    chk("post_d0", bus.seg, 7'b1000000);
    goto(64);
    chk("post_frame", bus.frame, 1'b1);
    goto(65);
    chk("post_an", bus.an, 8'hFE);
    chk("post_seg", bus.seg, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
